// File: rtl/enc8to3_req_if.sv
// +--------------------------------------------------------------------+
// | Module  : enc8to3_req_if                                           |
// | Brief   : Request/offer bundle between a requester and the encoder |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

interface enc8to3_req_if;
  logic [7:0] req_i;
  logic       clear_i;
  logic       ready_i;
  logic       valid_o;
  logic [2:0] idx_o;
  logic [7:0] pending_o;
  logic       overflow_o;

  modport master (
    output req_i, clear_i, ready_i,
    input  valid_o, idx_o, pending_o, overflow_o
  );

  modport slave (
    input  req_i, clear_i, ready_i,
    output valid_o, idx_o, pending_o, overflow_o
  );
endinterface

`default_nettype wire

// File: rtl/enc8to3_req.sv
// +--------------------------------------------------------------------+
// | Module  : enc8to3_req                                              |
// | Brief   : Registered 8-to-3 request encoder with sticky pending    |
// |           set and valid/ready offer, fixed or round-robin select   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module enc8to3_req #(
  parameter int RR_MODE = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  enc8to3_req_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] last_q, last_d;
  logic       valid_q, valid_d;
  logic       overflow_q, overflow_d;

  logic       handshake;
  logic [7:0] retire_mask;
  logic [7:0] rem;

  // Fixed mode: lowest set bit. Round-robin: first set bit after `last`, wrapping.
  function automatic logic [2:0] sel(input logic [7:0] v, input logic [2:0] last);
    logic [2:0] r;
    logic [2:0] p;
    logic       found;
    r     = '0;
    p     = '0;
    found = 1'b0;
    if (RR_MODE == 0) begin
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) r = 3'(i);
      end
    end else begin
      for (int k = 1; k <= 8; k++) begin
        p = last + 3'(k);
        if (!found && v[p]) begin
          r     = p;
          found = 1'b1;
        end
      end
    end
    return r;
  endfunction

  assign handshake   = valid_q & bus.ready_i;
  assign retire_mask = handshake ? (8'h01 << idx_q) : 8'h00;
  // New requests are OR'd after the retire so a same-cycle re-request survives.
  assign rem         = (pending_q & ~retire_mask) | bus.req_i;

  always_comb begin
    state_d    = state_q;
    pending_d  = rem;
    idx_d      = idx_q;
    last_d     = last_q;
    valid_d    = valid_q;
    overflow_d = |(bus.req_i & pending_q & ~retire_mask);

    if (bus.clear_i) begin
      pending_d  = 8'h00;
      valid_d    = 1'b0;
      overflow_d = 1'b0;
      state_d    = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (pending_q != 8'h00) begin
            idx_d   = sel(pending_q, last_q);
            valid_d = 1'b1;
            state_d = OFFER;
          end
        end
        OFFER: begin
          if (handshake) begin
            last_d = idx_q;
            if (rem != 8'h00) begin
              idx_d = sel(rem, idx_q);
            end else begin
              valid_d = 1'b0;
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      pending_q  <= 8'h00;
      idx_q      <= 3'd0;
      last_q     <= 3'd7;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.valid_o    = valid_q;
  assign bus.idx_o      = idx_q;
  assign bus.pending_o  = pending_q;
  assign bus.overflow_o = overflow_q;

endmodule

`default_nettype wire

// File: doc/enc8to3_req.md
Name: enc8to3_req

Overview:
- Registered 8-to-3 request encoder: the inverse of the 3-to-8 decoder.
- Captures up to 8 request lines into a sticky pending register. Offers the index of the selected pending request on a valid/ready handshake and retires it on acceptance.
- Sits in front of the core's trap/interrupt and arbitration paths, where one-hot or multi-hot request vectors must become a 3-bit index.

Parameters:
- RR_MODE, 0, selection policy: 0 = fixed priority (bit 0 highest); 1 = round-robin starting after the last granted index.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- req_i  input  8  request vector; each set bit is OR'd into pending every cycle.
- clear_i  input  1  synchronous flush of all pending requests and any open offer.
- ready_i  input  1  consumer accepts idx_o this cycle.
- valid_o  output  1  idx_o holds an offered request.
- idx_o  output  3  encoded index of the offered request.
- pending_o  output  8  current pending register.
- overflow_o  output  1  one-cycle pulse: a request hit an already-pending bit.

Behaviour:
- Reset (rst_ni low, asynchronous): pending_q=8'h00, valid_o=0, idx_o=3'd0, overflow_o=0, RR pointer last_q=3'd7 (so the first search starts at bit 0), FSM=IDLE. Reset mid-offer drops the offer immediately.
- Pending update each edge: pending_q <= (pending_q & ~retire_mask) | req_i.
  - retire_mask is the one-hot of idx_o when valid_o && ready_i, else 0.
  - Set wins over retire: a req_i bit equal to the index being retired stays pending.
- Selection function sel(v):
  - RR_MODE=0: lowest set bit index.
  - RR_MODE=1: first set bit scanning upward from last_q+1 modulo 8, wrapping 7 -> 0.
  - For any exactly-one-hot v, sel(v) equals the position of the set bit (inverse of the decoder).
- FSM states IDLE and OFFER:
  - IDLE: if pending_q != 0, load idx_q <= sel(pending_q), valid_o <= 1, go to OFFER. Otherwise stay.
  - OFFER, ready_i=0: idx_o and valid_o hold stable. Newly arriving higher-priority requests do not change the offer.
  - OFFER, ready_i=1 (handshake): retire idx_o, last_q <= idx_o. Let rem = (pending_q & ~retire_mask) | req_i.
    - If rem != 0: load idx_q <= sel(rem) using the updated pointer and stay in OFFER (back-to-back, one grant per cycle).
    - If rem == 0: valid_o <= 0, go to IDLE.
- Latency: req_i sampled at edge k -> pending_o set after edge k -> valid_o/idx_o presented after edge k+1 (2 edges from IDLE). Throughput is 1 grant/cycle while pending is non-empty.
- clear_i has highest priority below reset:
  - pending_q <= 0, valid_o <= 0, FSM -> IDLE, last_q unchanged.
  - req_i in the same cycle is discarded.
  - An in-flight handshake in that cycle still counts as accepted by the consumer, but has no further effect.
- overflow_o <= |(req_i & pending_q & ~retire_mask). Registered, one cycle, not sticky. Forced to 0 in a clear_i cycle.
- All outputs are registered; no combinational path from any input to any output.
- pending_o reflects pending_q, including the bit currently offered until it is retired.

Test Plan:
- Decoder round-trip: for i=0..7, drive req_i=(1<<i) for one cycle with ready_i=1 -> valid_o high 2 edges later with idx_o=i for exactly one cycle, pending_o returns to 8'h00.
- Fixed priority, multi-hot: RR_MODE=0, req_i=8'b1010_0100 for one cycle, ready_i=1 -> idx_o sequence 2,5,7 on consecutive cycles, then valid_o=0.
- Round-robin wrap: RR_MODE=1, grant idx 6, then req_i=8'b0100_0001 -> next grants 0 then 6. With bits 1 and 7 pending and last_q=6, the order is 7 then 1.
- Stall stability: hold ready_i=0 with offer idx_o=4, then assert req_i=8'h01 -> idx_o stays 4 until ready_i=1, then 0 is offered next cycle.
- Set-vs-retire collision: offering idx 3, ready_i=1 and req_i=8'h08 same cycle -> bit 3 remains pending, idx_o=3 offered again, overflow_o=0. Repeat req_i=8'h08 while 3 pending and ready_i=0 -> overflow_o pulses 1 cycle.
- Flush and reset: pending=8'hFF with offer open, pulse clear_i with req_i=8'h10 -> next cycle pending_o=8'h00, valid_o=0. Assert rst_ni low mid-offer -> valid_o=0 and idx_o=0 immediately, without waiting for a clock edge.
